display_scan: RTL



---
 rtl/display_pkg.sv | 23 ++
 rtl/display_scan_if.sv | 28 ++
 rtl/bcd_to_7seg.sv | 27 ++
 rtl/display_scan.sv | 126 ++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants for the 6-digit multiplexed
// 7-segment scan display (segments active-low {g,f,e,d,c,b,a}).
package display_pkg;

  localparam int N_DIGITS = 6;
  localparam int IDX_W    = 3;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [N_DIGITS-1:0] AN_OFF = 6'b111111;

endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: BCD digit inputs from the counter chain
// and the multiplexed display outputs.
interface display_scan_if;
  import display_pkg::*;

  logic [3:0]          d0;
  logic [3:0]          d1;
  logic [3:0]          d2;
  logic [3:0]          d3;
  logic [3:0]          d4;
  logic [3:0]          d5;
  logic                blank;
  logic [N_DIGITS-1:0] an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame_tick;

  modport master (
    output d0, d1, d2, d3, d4, d5, blank,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  d0, d1, d2, d3, d4, d5, blank,
    output an, seg, dp, frame_tick
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low segment decoder;
// codes 10..15 render as a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// display_scan: frame-snapshot 6-digit 7-seg scanner.
// Define DISPLAY_LZB_EN for leading-zero blanking.
module display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DP_DIGIT    = 2
) (
  input  logic         clk,
  input  logic         rst,
  display_scan_if.slave scan
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX =
    PW'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX =
    IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0] DP_IDX =
    IDX_W'(DP_DIGIT);

  logic [PW-1:0]       pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          snap_q [N_DIGITS];
  logic [3:0]          din    [N_DIGITS];
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                tick_q;

  logic                wrap;
  logic                snap_en;
  logic [3:0]          cur;
  logic                lz_cur;
  logic                off;
  logic [6:0]          seg_dec;
  logic [N_DIGITS-1:0] lz;

  assign din[0] = scan.d0;
  assign din[1] = scan.d1;
  assign din[2] = scan.d2;
  assign din[3] = scan.d3;
  assign din[4] = scan.d4;
  assign din[5] = scan.d5;

  assign wrap    = (pre_q == PRE_MAX);
  assign snap_en = wrap && (idx_q == IDX_MAX);

  always_comb begin
    pre_d = wrap ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef DISPLAY_LZB_EN
  logic zrun;

  // Digit i is a leading zero if it and every higher digit are zero.
  always_comb begin
    zrun = 1'b1;
    lz   = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zrun = zrun & (snap_q[i] == 4'd0);
      if (i > DP_DIGIT) lz[i] = zrun;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    cur    = snap_q[0];
    lz_cur = lz[0];
    for (int i = 1; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur    = snap_q[i];
        lz_cur = lz[i];
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd_i (cur),
    .seg_o (seg_dec)
  );

  assign off   = scan.blank | lz_cur;
  assign an_d  = off ? AN_OFF
                     : ~(N_DIGITS'(1) << idx_q);
  assign seg_d = seg_dec;
  assign dp_d  = ~((idx_q == DP_IDX) & ~off);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      idx_q  <= '0;
      for (int i = 0; i < N_DIGITS; i++) begin
        snap_q[i] <= 4'd0;
      end
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      if (snap_en) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          snap_q[i] <= din[i];
        end
      end
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= snap_en;
    end
  end

  assign scan.an         = an_q;
  assign scan.seg        = seg_q;
  assign scan.dp         = dp_q;
  assign scan.frame_tick = tick_q;

endmodule
